// File: rtl/locked_multicycle_adder.sv
// Key-locked adder that processes CHUNK bits per cycle; a wrong key corrupts sum and carry bits.
// Optional feature: define LOCK_OP_COUNT_EN to add the saturating op_cnt_o completion counter.
module locked_multicycle_adder #(
    parameter int                   WIDTH       = 16,
    parameter int                   KEY_WIDTH   = 32,
    parameter int                   CHUNK       = 4,
    parameter logic [KEY_WIDTH-1:0] CORRECT_KEY = 32'h2E798869
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             key_load_i,
    input  logic             key_bit_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] add1_i,
    input  logic [WIDTH-1:0] add2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH:0]   result_o
`ifdef LOCK_OP_COUNT_EN
    ,
    output logic [15:0]      op_cnt_o
`endif
);

    localparam int NCH   = WIDTH / CHUNK;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t               state;
    logic [KEY_WIDTH-1:0] key_sr;
    logic [KEY_WIDTH-1:0] key_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH-1:0]     sum_q;
    logic [IDX_W-1:0]     idx;
    logic                 carry;

    logic [WIDTH-1:0]     e_vec;
    logic [WIDTH-1:0]     f_vec;
    logic [WIDTH-1:0]     next_sum;
    logic [CHUNK-1:0]     a_c;
    logic [CHUNK-1:0]     b_c;
    logic [CHUNK-1:0]     e_c;
    logic [CHUNK-1:0]     f_c;
    logic [CHUNK-1:0]     s_c;
    logic                 c_out;
    logic                 last_chunk;
    int                   base;

    // Key bits above 2*WIDTH never reach the datapath.
    // NOTE: the ripple chain reuses c_out bit by bit, so it must be a blocking
    // assignment; every variable also gets a default to avoid inferring latches.
    always_comb begin
        e_vec    = key_q[WIDTH-1:0] ^ CORRECT_KEY[WIDTH-1:0];
        f_vec    = key_q[2*WIDTH-1:WIDTH] ^ CORRECT_KEY[2*WIDTH-1:WIDTH];
        base     = int'(idx) * CHUNK;
        a_c      = a_q[base +: CHUNK];
        b_c      = b_q[base +: CHUNK];
        e_c      = e_vec[base +: CHUNK];
        f_c      = f_vec[base +: CHUNK];
        s_c      = '0;
        c_out    = carry;
        for (int j = 0; j < CHUNK; j++) begin
            s_c[j] = a_c[j] ^ b_c[j] ^ c_out ^ e_c[j];
            c_out  = ((a_c[j] & b_c[j]) | (a_c[j] & c_out) | (b_c[j] & c_out)) ^ f_c[j];
        end
        next_sum              = sum_q;
        next_sum[base +: CHUNK] = s_c;
        last_chunk            = (idx == IDX_W'(NCH - 1));
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            key_sr <= '0;
        end else if (key_load_i) begin
            key_sr <= (key_sr << 1) | KEY_WIDTH'(key_bit_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            result_o <= '0;
            key_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            idx      <= '0;
            carry    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        a_q    <= add1_i;
                        b_q    <= add2_i;
                        key_q  <= key_sr;
                        sum_q  <= '0;
                        idx    <= '0;
                        carry  <= 1'b0;
                        busy_o <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    sum_q <= next_sum;
                    carry <= c_out;
                    idx   <= idx + 1'b1;
                    if (last_chunk) begin
                        result_o <= {c_out, next_sum};
                        busy_o   <= 1'b0;
                        done_o   <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: begin
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

`ifdef LOCK_OP_COUNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_cnt_o <= '0;
        end else if (state == RUN && last_chunk && op_cnt_o != 16'hFFFF) begin
            op_cnt_o <= op_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_locked_multicycle_adder.sv
// Randomised self-checking bench for locked_multicycle_adder against a bitwise reference model.
module tb_locked_multicycle_adder;

    localparam int          W    = 16;
    localparam int          NCH  = 4;
    localparam logic [31:0] CKEY = 32'h2E798869;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          key_load_i = 1'b0;
    logic          key_bit_i = 1'b0;
    logic          start_i = 1'b0;
    logic [W-1:0]  add1_i = '0;
    logic [W-1:0]  add2_i = '0;
    logic          busy_o;
    logic          done_o;
    logic [W:0]    result_o;
`ifdef LOCK_OP_COUNT_EN
    logic [15:0]   op_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    locked_multicycle_adder dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .key_load_i (key_load_i),
        .key_bit_i  (key_bit_i),
        .start_i    (start_i),
        .add1_i     (add1_i),
        .add2_i     (add2_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o)
`ifdef LOCK_OP_COUNT_EN
        ,
        .op_cnt_o   (op_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Reference: plain addition when unlocked, otherwise the per-bit corruption equations.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [31:0] key);
        logic [W:0] r;
        logic       c;
        logic       e;
        logic       f;
        if (key == CKEY) return {1'b0, a} + {1'b0, b};
        r = '0;
        c = 1'b0;
        for (int i = 0; i < W; i++) begin
            e    = key[i] ^ CKEY[i];
            f    = key[W+i] ^ CKEY[W+i];
            r[i] = a[i] ^ b[i] ^ c ^ e;
            c    = ((a[i] & b[i]) | (a[i] & c) | (b[i] & c)) ^ f;
        end
        r[W] = c;
        return r;
    endfunction

    task automatic apply_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        start_i = 1'b0;
        key_load_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic load_key(input logic [31:0] key);
        for (int i = 31; i >= 0; i--) begin
            @(negedge clk_i);
            key_load_i = 1'b1;
            key_bit_i  = key[i];
        end
        @(negedge clk_i);
        key_load_i = 1'b0;
    endtask

    // Starts one operation and checks busy, latency, result, pulse width and hold.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W:0] exp,
                         input bit scramble, input string name);
        int k;
        bit seen;
        @(negedge clk_i);
        start_i = 1'b1;
        add1_i  = a;
        add2_i  = b;
        @(negedge clk_i);
        start_i = 1'b0;
        add1_i  = W'($urandom);
        add2_i  = W'($urandom);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL %s busy: got %b want 1", name, busy_o);
        end
        k = 1;
        seen = 1'b0;
        while (!seen && k < 20) begin
            if (scramble) begin
                key_load_i = 1'b1;
                key_bit_i  = 1'($urandom);
            end
            if (done_o === 1'b1) seen = 1'b1;
            else begin
                @(negedge clk_i);
                k++;
            end
        end
        key_load_i = 1'b0;
        checks++;
        if (!seen || (k - 1) != NCH) begin
            errors++;
            $display("FAIL %s latency: got %0d (seen=%b) want %0d", name, k - 1, seen, NCH);
        end
        checks++;
        if (result_o !== exp) begin
            errors++;
            $display("FAIL %s result: got %h want %h", name, result_o, exp);
        end
        @(negedge clk_i);
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || result_o !== exp) begin
            errors++;
            $display("FAIL %s after_done: done=%b busy=%b result=%h want 0/0/%h",
                     name, done_o, busy_o, result_o, exp);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b result=%h want 0/0/0", busy_o, done_o, result_o);
        end
    endtask

    task automatic test_known_vectors();
        load_key(32'h2E798869);
        do_op(16'h0001, 16'hFFFF, 17'h10000, 1'b0, "correct_key");
        load_key(32'h2E798868);
        do_op(16'h0001, 16'hFFFF, 17'h10001, 1'b0, "key_bit0_wrong");
        load_key(32'h2E788869);
        do_op(16'h0001, 16'hFFFF, 17'h0FFFE, 1'b0, "key_bit16_wrong");
    endtask

    task automatic test_random_ops();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [31:0]  key;
        load_key(CKEY);
        for (int i = 0; i < 12; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            do_op(a, b, model(a, b, CKEY), 1'b0, "rand_unlocked");
        end
        do_op(16'hFFFF, 16'hFFFF, 17'h1FFFE, 1'b0, "max_operands");
        do_op(16'h0000, 16'h0000, 17'h00000, 1'b0, "zero_operands");
        for (int i = 0; i < 6; i++) begin
            key = $urandom;
            load_key(key);
            a = W'($urandom);
            b = W'($urandom);
            do_op(a, b, model(a, b, key), 1'b0, "rand_key");
        end
    endtask

    task automatic test_key_frozen_in_run();
        logic [W-1:0] a;
        logic [W-1:0] b;
        load_key(CKEY);
        a = W'($urandom);
        b = W'($urandom);
        do_op(a, b, model(a, b, CKEY), 1'b1, "key_shift_in_run");
    endtask

    task automatic test_back_to_back();
        int ndone;
        logic exp_done;
        load_key(CKEY);
        ndone = 0;
        @(negedge clk_i);
        start_i = 1'b1;
        add1_i  = 16'h1234;
        add2_i  = 16'h4321;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk_i);
            if (k == 12) start_i = 1'b0;
            exp_done = (k == 5 || k == 10 || k == 15);
            checks++;
            if (done_o !== exp_done) begin
                errors++;
                $display("FAIL b2b_done k=%0d: got %b want %b", k, done_o, exp_done);
            end
            if (done_o === 1'b1) begin
                ndone++;
                checks++;
                if (result_o !== 17'h05555) begin
                    errors++;
                    $display("FAIL b2b_result k=%0d: got %h want 05555", k, result_o);
                end
            end
        end
        checks++;
        if (ndone != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d want 3", ndone);
        end
    endtask

    task automatic test_reset_mid_run();
        int nd;
        load_key(CKEY);
        @(negedge clk_i);
        start_i = 1'b1;
        add1_i  = 16'h00FF;
        add2_i  = 16'h0F0F;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        start_i = 1'b1;
        key_load_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        start_i = 1'b0;
        key_load_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== '0) begin
            errors++;
            $display("FAIL mid_run_reset: busy=%b done=%b result=%h want 0/0/0", busy_o, done_o, result_o);
        end
        nd = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            if (done_o === 1'b1 || busy_o === 1'b1) nd++;
        end
        checks++;
        if (nd != 0) begin
            errors++;
            $display("FAIL aborted_activity: got %0d active cycles want 0", nd);
        end
        load_key(CKEY);
        do_op(16'h00FF, 16'h0F0F, 17'h0100E, 1'b0, "after_abort");
    endtask

`ifdef LOCK_OP_COUNT_EN
    task automatic test_op_count();
        apply_reset();
        load_key(CKEY);
        for (int i = 0; i < 3; i++) do_op(16'(i), 16'h0010, 17'(i + 16), 1'b0, "cnt_op");
        checks++;
        if (op_cnt_o !== 16'd3) begin
            errors++;
            $display("FAIL op_cnt: got %0d want 3", op_cnt_o);
        end
        apply_reset();
        checks++;
        if (op_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL op_cnt_reset: got %0d want 0", op_cnt_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_known_vectors();
        test_random_ops();
        test_key_frozen_in_run();
        test_back_to_back();
        test_reset_mid_run();
`ifdef LOCK_OP_COUNT_EN
        test_op_count();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
